// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared types and constants for the FIFO read-side stream stage.
// Skid depth, pointer/occupancy types and pointer wrap helper.
package fifo_rd_pkg;

  localparam int SKID_DEPTH     = 3;
  localparam int FIFO_WIDTH_DEF = 16;

  typedef logic [1:0] occ_t;
  typedef logic [1:0] ptr_t;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(SKID_DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid: 3-entry circular skid buffer.
// Absorbs the FIFO read latency; head word is driven straight from storage.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int W = FIFO_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output occ_t         occ,
  output logic [W-1:0] head
);

  logic [W-1:0] mem [SKID_DEPTH];
  ptr_t         wr_ptr;
  ptr_t         rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      occ <= occ + occ_t'(push) - occ_t'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: FIFO read side re-presented as a valid/ready stream.
// Issue logic, in-flight tracking, statistics and sticky underflow error.
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr_stats,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic [CNT_WIDTH-1:0]  stall_count,
  output logic                  err_underflow
);

  occ_t       occ;
  logic       inflight;
  logic       pop;
  logic [2:0] pending;

  // Credit check uses only registered state, so m_ready never reaches rd_en.
  assign pending    = {1'b0, occ} + {2'b00, inflight};
  assign fifo_rd_en = rst_n & en & ~fifo_empty
                    & (pending < 3'(SKID_DEPTH));

  assign m_valid = (occ != '0);
  assign pop     = m_valid & m_ready;

  fifo_rd_skid #(
    .W(FIFO_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (inflight),
    .push_data(fifo_data_out),
    .pop      (pop),
    .occ      (occ),
    .head     (m_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight <= 1'b0;
    else        inflight <= fifo_rd_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count      <= '0;
      stall_count   <= '0;
      err_underflow <= 1'b0;
    end else if (clr_stats) begin
      rd_count      <= '0;
      stall_count   <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (fifo_rd_en)
        rd_count <= rd_count + CNT_WIDTH'(1);
      if (m_valid & ~m_ready & ~&stall_count)
        stall_count <= stall_count + CNT_WIDTH'(1);
      if (fifo_underflow)
        err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed + random bench with queue-based FIFO model
// and a word-order scoreboard for the stream output.
module tb_fifo_rd_stream;

  localparam int W  = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          clr_stats = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          fifo_underflow = 1'b0;
  logic [W-1:0]  fifo_data_out = '0;
  logic          fifo_rd_en;
  logic [W-1:0]  m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [CW-1:0] rd_count;
  logic [CW-1:0] stall_count;
  logic          err_underflow;

  always #5 clk = ~clk;

  fifo_rd_stream #(
    .FIFO_WIDTH(W),
    .CNT_WIDTH (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .clr_stats     (clr_stats),
    .fifo_empty    (fifo_empty),
    .fifo_underflow(fifo_underflow),
    .fifo_data_out (fifo_data_out),
    .fifo_rd_en    (fifo_rd_en),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .rd_count      (rd_count),
    .stall_count   (stall_count),
    .err_underflow (err_underflow)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural FIFO: registered empty flag and 1-cycle read data.
  logic [W-1:0] mem[$];
  logic [W-1:0] pend[$];
  logic [W-1:0] exp_q[$];

  always @(posedge clk) begin
    if (fifo_rd_en && mem.size() > 0) fifo_data_out <= mem.pop_front();
    while (pend.size() > 0) mem.push_back(pend.pop_front());
    fifo_empty <= (mem.size() == 0);
  end

  task automatic push_word(input logic [W-1:0] d);
    pend.push_back(d);
    exp_q.push_back(d);
  endtask

  // Monitor / reference model, sampled on the falling edge.
  int cyc = 0, rd_seen = 0, beats = 0, outst = 0;
  int rd_run = 0, rd_run_max = 0;
  int first_rd = -1, first_valid = -1, first_beat = -1, last_beat = -1;
  logic [CW-1:0] rd_exp = '0, st_exp = '0;
  logic          err_exp = 1'b0;
  logic          hold = 1'b0;
  logic [W-1:0]  hold_data = '0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      check("rst_valid", 32'(m_valid), 0);
      check("rst_rd_en", 32'(fifo_rd_en), 0);
      rd_exp = '0; st_exp = '0; err_exp = 1'b0;
      hold = 1'b0; outst = 0; rd_run = 0;
    end else begin
      check("rd_count", 32'(rd_count), 32'(rd_exp));
      check("stall_count", 32'(stall_count), 32'(st_exp));
      check("err_underflow", 32'(err_underflow), 32'(err_exp));
      check("outstanding_le3", 32'(outst <= 3), 1);
      if (hold) begin
        check("hold_valid", 32'(m_valid), 1);
        check("hold_data", 32'(m_data), 32'(hold_data));
      end
      if (fifo_rd_en) begin
        check("rd_nonempty", 32'(fifo_empty), 0);
        rd_seen++; outst++; rd_run++;
        if (rd_run > rd_run_max) rd_run_max = rd_run;
        if (first_rd < 0) first_rd = cyc;
      end else begin
        rd_run = 0;
      end
      if (m_valid && first_valid < 0) first_valid = cyc;
      if (m_valid && m_ready) begin
        beats++; outst--;
        if (first_beat < 0) first_beat = cyc;
        last_beat = cyc;
        if (exp_q.size() == 0) check("beat_extra", 1, 0);
        else check("beat_data", 32'(m_data), 32'(exp_q.pop_front()));
      end
      hold      = m_valid && !m_ready;
      hold_data = m_data;
      if (clr_stats) begin
        rd_exp = '0; st_exp = '0; err_exp = 1'b0;
      end else begin
        if (fifo_rd_en) rd_exp = rd_exp + 1'b1;
        if (m_valid && !m_ready && st_exp != '1) st_exp = st_exp + 1'b1;
        if (fifo_underflow) err_exp = 1'b1;
      end
    end
  end

  int m_rd, m_beats;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mark();
    m_rd = rd_seen; m_beats = beats;
    rd_run_max = 0;
    first_rd = -1; first_valid = -1; first_beat = -1; last_beat = -1;
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget && (exp_q.size() != 0 || outst != 0); k++)
      tick();
    check("drain_left", 32'(exp_q.size()), 0);
  endtask

  initial begin
    en = 1'b1; m_ready = 1'b1;
    tick();
    check("rst_m_data", 32'(m_data), 0);
    check("rst_rd_count", 32'(rd_count), 0);
    check("rst_stall", 32'(stall_count), 0);
    check("rst_err", 32'(err_underflow), 0);

    // Single word; reads are held off while still in reset.
    push_word(16'hA5A5);
    tick(3);
    mark();
    rst_n = 1'b1;
    tick(6);
    check("single_latency", 32'(first_valid - first_rd), 2);
    check("single_rd_count", 32'(rd_count), 1);
    check("single_rd_run", 32'(rd_run_max), 1);
    check("single_beats", 32'(beats - m_beats), 1);

    // Burst at full rate.
    mark();
    for (int i = 1; i <= 8; i++) push_word(16'(i));
    tick(16);
    check("burst_rd_run", 32'(rd_run_max), 8);
    check("burst_beats", 32'(beats - m_beats), 8);
    check("burst_back2back", 32'(last_beat - first_beat), 7);
    check("burst_stall", 32'(stall_count), 0);
    check("burst_rd_count", 32'(rd_count), 9);

    // Backpressure: only the skid credit worth of reads goes out.
    m_ready = 1'b0;
    mark();
    for (int i = 1; i <= 8; i++) push_word(16'(i));
    tick(12);
    check("bp_reads", 32'(rd_seen - m_rd), 3);
    check("bp_rd_en", 32'(fifo_rd_en), 0);
    check("bp_valid", 32'(m_valid), 1);
    check("bp_head", 32'(m_data), 32'h0001);
    check("bp_stalled", 32'(stall_count > 0), 1);
    m_ready = 1'b1;
    drain(100);
    check("bp_beats", 32'(beats - m_beats), 8);

    // en gating.
    en = 1'b0;
    mark();
    for (int i = 0; i < 4; i++) push_word(16'h0100 + 16'(i));
    tick(6);
    check("en0_reads", 32'(rd_seen - m_rd), 0);
    check("en0_valid", 32'(m_valid), 0);
    en = 1'b1;
    tick();
    en = 1'b0;
    tick(6);
    check("en_pulse_reads", 32'(rd_seen - m_rd), 1);
    check("en_pulse_beats", 32'(beats - m_beats), 1);
    en = 1'b1;
    drain(100);

    // Sticky underflow and stats clear.
    fifo_underflow = 1'b1;
    tick();
    fifo_underflow = 1'b0;
    tick(3);
    check("uf_sticky", 32'(err_underflow), 1);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    check("clr_err", 32'(err_underflow), 0);
    check("clr_rd_count", 32'(rd_count), 0);
    check("clr_stall", 32'(stall_count), 0);

    // Reset mid-burst with words buffered.
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_word(16'h0200 + 16'(i));
    begin
      int k;
      for (k = 0; k < 20 && !m_valid; k++) tick();
      check("mid_valid_seen", 32'(m_valid), 1);
    end
    tick();
    rst_n = 1'b0;
    exp_q = {mem, pend};
    #1;
    check("mid_rst_valid", 32'(m_valid), 0);
    check("mid_rst_rd_en", 32'(fifo_rd_en), 0);
    tick(2);
    rst_n = 1'b1;
    m_ready = 1'b1;
    drain(100);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      en             = ($urandom_range(0, 3) != 0);
      m_ready        = ($urandom_range(0, 2) != 0);
      clr_stats      = ($urandom_range(0, 99) == 0);
      fifo_underflow = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 2) == 0) push_word(16'($urandom));
      tick();
    end
    en = 1'b1; m_ready = 1'b1;
    clr_stats = 1'b0; fifo_underflow = 1'b0;
    drain(3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
